// File: rtl/lane_phase_scheduler.sv
// rtl/lane_phase_scheduler.sv - round-robin lane green/yellow/all-red sequencer with walk and emergency preemption
// Optional macro GREEN_EXTEND_EN: green extends past GREEN_MIN up to GREEN_MAX while only the granted lane requests.
module lane_phase_scheduler #(
    parameter int GREEN_MIN   = 10,
    parameter int GREEN_MAX   = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lane_req,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic [2:0] emg_lane,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic       walk,
    output logic [2:0] phase,
    output logic [6:0] time_left,
    output logic [2:0] grant_lane
);

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_WALK    = 3'd3,
        ST_EMG     = 3'd4
    } state_t;

`ifdef GREEN_EXTEND_EN
    localparam logic EXTEND = 1'b1;
`else
    localparam logic EXTEND = 1'b0;
`endif

    localparam logic [6:0] T_GREEN_MIN = 7'(GREEN_MIN);
    localparam logic [6:0] T_GREEN_MAX = 7'(GREEN_MAX);
    localparam logic [6:0] T_YELLOW    = 7'(YELLOW_TIME);
    localparam logic [6:0] T_ALLRED    = 7'(ALLRED_TIME);
    localparam logic [6:0] T_WALK      = 7'(WALK_TIME);

    state_t     state;
    logic [2:0] ptr;
    logic       ped_pending;
    logic [6:0] green_cnt;
    logic [2:0] rr_lane;
    logic [2:0] rr_idx;
    logic       rr_found;
    logic       extend_ok;

    assign phase = state;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        rr_lane  = 3'd0;
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            rr_idx = ptr + 3'(i);
            if (lane_req[rr_idx]) begin
                rr_lane  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // green_cnt counts green cycles including the current one.
    always_comb begin
        extend_ok = EXTEND && (lane_req == (8'b1 << grant_lane)) && !ped_pending
                    && !emg_req && (green_cnt < T_GREEN_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ALL_RED;
            time_left   <= T_ALLRED;
            green       <= 8'h00;
            yellow      <= 8'h00;
            walk        <= 1'b0;
            grant_lane  <= 3'd0;
            ptr         <= 3'd0;
            ped_pending <= 1'b0;
            green_cnt   <= 7'd0;
        end else begin
            ped_pending <= ped_pending | ped_req;
            case (state)
                ST_ALL_RED: begin
                    if (time_left == 7'd1) begin
                        if (emg_req) begin
                            state      <= ST_EMG;
                            grant_lane <= emg_lane;
                            green      <= 8'b1 << emg_lane;
                            time_left  <= 7'd0;
                        end else if (ped_pending) begin
                            state       <= ST_WALK;
                            walk        <= 1'b1;
                            time_left   <= T_WALK;
                            ped_pending <= ped_req;
                        end else if (rr_found) begin
                            state      <= ST_GREEN;
                            grant_lane <= rr_lane;
                            green      <= 8'b1 << rr_lane;
                            time_left  <= T_GREEN_MIN;
                            green_cnt  <= 7'd1;
                            ptr        <= rr_lane + 3'd1;
                        end
                    end else begin
                        time_left <= time_left - 7'd1;
                    end
                end
                ST_GREEN: begin
                    if (emg_req && emg_lane == grant_lane) begin
                        state     <= ST_EMG;
                        time_left <= 7'd0;
                    end else if (emg_req || (time_left == 7'd1 && !extend_ok)) begin
                        state     <= ST_YELLOW;
                        green     <= 8'h00;
                        yellow    <= 8'b1 << grant_lane;
                        time_left <= T_YELLOW;
                    end else begin
                        if (time_left != 7'd1) time_left <= time_left - 7'd1;
                        green_cnt <= green_cnt + 7'd1;
                    end
                end
                ST_YELLOW: begin
                    if (time_left == 7'd1) begin
                        state     <= ST_ALL_RED;
                        yellow    <= 8'h00;
                        time_left <= T_ALLRED;
                    end else begin
                        time_left <= time_left - 7'd1;
                    end
                end
                ST_WALK: begin
                    if (time_left == 7'd1) begin
                        state     <= ST_ALL_RED;
                        walk      <= 1'b0;
                        time_left <= T_ALLRED;
                    end else begin
                        time_left <= time_left - 7'd1;
                    end
                end
                ST_EMG: begin
                    if (!emg_req) begin
                        state     <= ST_YELLOW;
                        green     <= 8'h00;
                        yellow    <= 8'b1 << grant_lane;
                        time_left <= T_YELLOW;
                    end
                end
                default: begin
                    state     <= ST_ALL_RED;
                    time_left <= T_ALLRED;
                    green     <= 8'h00;
                    yellow    <= 8'h00;
                    walk      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// tb/tb_lane_phase_scheduler.sv - directed self-checking bench for lane_phase_scheduler
module tb_lane_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lane_req;
    logic       ped_req;
    logic       emg_req;
    logic [2:0] emg_lane;
    logic [7:0] green;
    logic [7:0] yellow;
    logic       walk;
    logic [2:0] phase;
    logic [6:0] time_left;
    logic [2:0] grant_lane;

    int errors = 0;
    int checks = 0;

    lane_phase_scheduler dut (
        .clk(clk), .rst(rst), .lane_req(lane_req), .ped_req(ped_req),
        .emg_req(emg_req), .emg_lane(emg_lane), .green(green), .yellow(yellow),
        .walk(walk), .phase(phase), .time_left(time_left), .grant_lane(grant_lane)
    );

    always #5 clk = ~clk;

    // One expected segment: phase, lamps, starting time_left (0 = untimed), length, granted lane.
    typedef struct {
        logic [2:0] ph;
        logic [7:0] g;
        logic [7:0] y;
        logic       w;
        logic [6:0] tl;
        int         len;
        logic [2:0] gl;
    } seg_t;

    function automatic seg_t mk(logic [2:0] ph, logic [7:0] g, logic [7:0] y, logic w,
                                logic [6:0] tl, int len, logic [2:0] gl);
        seg_t r;
        r.ph = ph; r.g = g; r.y = y; r.w = w; r.tl = tl; r.len = len; r.gl = gl;
        return r;
    endfunction

    function automatic logic [6:0] exp_tl(logic [6:0] tl, int k);
        if (tl == 7'd0) return 7'd0;
        if (tl > 7'(k)) return tl - 7'(k);
        return 7'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lane_req = 8'h00; ped_req = 1'b0; emg_req = 1'b0; emg_lane = 3'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lane_req = 8'hff; ped_req = 1'b1; emg_req = 1'b1; emg_lane = 3'd6;
        tick();
        tick();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d want=0", phase); end
        checks++; if (time_left !== 7'd2) begin errors++; $display("FAIL reset_time_left got=%0d want=2", time_left); end
        checks++; if (green !== 8'h00) begin errors++; $display("FAIL reset_green got=%h want=00", green); end
        checks++; if (yellow !== 8'h00) begin errors++; $display("FAIL reset_yellow got=%h want=00", yellow); end
        checks++; if (walk !== 1'b0) begin errors++; $display("FAIL reset_walk got=%b want=0", walk); end
        checks++; if (grant_lane !== 3'd0) begin errors++; $display("FAIL reset_grant_lane got=%0d want=0", grant_lane); end
        rst = 1'b0; lane_req = 8'h00; ped_req = 1'b0; emg_req = 1'b0;
    endtask

    task automatic test_single_lane();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h04;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h04, 8'h00, 1'b0, 7'd10, 10, 3'd2));
        s.push_back(mk(3'd2, 8'h00, 8'h04, 1'b0, 7'd3, 3, 3'd2));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd2));
        s.push_back(mk(3'd1, 8'h04, 8'h00, 1'b0, 7'd10, 1, 3'd2));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL single_lane seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                tick();
            end
        end
    endtask

    task automatic test_round_robin();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h81;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h01, 8'h00, 1'b0, 7'd10, 10, 3'd0));
        s.push_back(mk(3'd2, 8'h00, 8'h01, 1'b0, 7'd3, 3, 3'd0));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h80, 8'h00, 1'b0, 7'd10, 10, 3'd7));
        s.push_back(mk(3'd2, 8'h00, 8'h80, 1'b0, 7'd3, 3, 3'd7));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd7));
        s.push_back(mk(3'd1, 8'h01, 8'h00, 1'b0, 7'd10, 1, 3'd0));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL round_robin seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                tick();
            end
        end
    endtask

    task automatic test_ped_during_green();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h08;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h08, 8'h00, 1'b0, 7'd10, 10, 3'd3));
        s.push_back(mk(3'd2, 8'h00, 8'h08, 1'b0, 7'd3, 3, 3'd3));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd3));
        s.push_back(mk(3'd3, 8'h00, 8'h00, 1'b1, 7'd8, 8, 3'd3));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd3));
        s.push_back(mk(3'd1, 8'h08, 8'h00, 1'b0, 7'd10, 1, 3'd3));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL ped_green seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                ped_req = (i == 1 && k == 3);
                tick();
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_idle_ped();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 6, 3'd0));
        s.push_back(mk(3'd3, 8'h00, 8'h00, 1'b1, 7'd8, 8, 3'd0));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 4, 3'd0));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL idle_ped seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                ped_req = (i == 0 && k == 4);
                tick();
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_emg_other_lane();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h02;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h02, 8'h00, 1'b0, 7'd10, 4, 3'd1));
        s.push_back(mk(3'd2, 8'h00, 8'h02, 1'b0, 7'd3, 3, 3'd1));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd1));
        s.push_back(mk(3'd4, 8'h20, 8'h00, 1'b0, 7'd0, 5, 3'd5));
        s.push_back(mk(3'd2, 8'h00, 8'h20, 1'b0, 7'd3, 3, 3'd5));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL emg_other seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                if (i == 1 && k == 3) begin emg_req = 1'b1; emg_lane = 3'd5; end
                if (i == 4 && k == 1) emg_lane = 3'd3;
                if (i == 4 && k == 4) emg_req = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_emg_same_lane_reset();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h10;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h10, 8'h00, 1'b0, 7'd10, 3, 3'd4));
        s.push_back(mk(3'd4, 8'h10, 8'h00, 1'b0, 7'd0, 3, 3'd4));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL emg_same seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                if (i == 1 && k == 2) begin emg_req = 1'b1; emg_lane = 3'd4; end
                if (i == 2 && k == 2) rst = 1'b1;
                tick();
            end
        end
        checks++;
        if ({phase, green, yellow, walk, time_left, grant_lane} !== {3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 3'd0}) begin
            errors++;
            $display("FAIL emg_mid_reset: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=0 g=00 y=00 w=0 tl=2 gl=0",
                     phase, green, yellow, walk, time_left, grant_lane);
        end
        rst = 1'b0; emg_req = 1'b0;
    endtask

    task automatic test_extend();
        seg_t s[$];
        logic [6:0] etl;
        do_reset();
        lane_req = 8'h01;
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h01, 8'h00, 1'b0, 7'd10, 30, 3'd0));
        s.push_back(mk(3'd2, 8'h00, 8'h01, 1'b0, 7'd3, 3, 3'd0));
        s.push_back(mk(3'd0, 8'h00, 8'h00, 1'b0, 7'd2, 2, 3'd0));
        s.push_back(mk(3'd1, 8'h01, 8'h00, 1'b0, 7'd10, 15, 3'd0));
        s.push_back(mk(3'd2, 8'h00, 8'h01, 1'b0, 7'd3, 3, 3'd0));
        for (int i = 0; i < s.size(); i++) begin
            for (int k = 0; k < s[i].len; k++) begin
                etl = exp_tl(s[i].tl, k);
                checks++;
                if ({phase, green, yellow, walk, time_left, grant_lane} !== {s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl}) begin
                    errors++;
                    $display("FAIL extend seg%0d cyc%0d: got ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d want ph=%0d g=%h y=%h w=%b tl=%0d gl=%0d",
                             i, k, phase, green, yellow, walk, time_left, grant_lane, s[i].ph, s[i].g, s[i].y, s[i].w, etl, s[i].gl);
                end
                if (i == 4 && k == 14) lane_req = 8'h03;
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1; lane_req = 8'h00; ped_req = 1'b0; emg_req = 1'b0; emg_lane = 3'd0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_ped_during_green();
        test_idle_ped();
        test_emg_other_lane();
        test_emg_same_lane_reset();
`ifdef GREEN_EXTEND_EN
        test_extend();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
